// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular FIFO.
// Bytes queue on wr_en and shift out LSB-first on tx.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push;
  logic          pop;
  logic          baud_done;

  assign full      = count == DEPTH;
  assign empty     = count == '0;
  assign busy      = (state != IDLE) || !empty;
  assign baud_done = baud == BAUD_LAST;
  assign push      = wr_en && !full;
  assign pop       = !empty &&
                     ((state == IDLE) ||
                      (state == STOP && baud_done));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      // a dropped write beats a simultaneous clear
      if (wr_en && full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      baud <= baud_done ? '0 : baud + 1'b1;
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (baud_done) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shift[1];
            end
          end
        end
        STOP: begin
          if (baud_done) begin
            // chain straight into the next start bit
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus for uart_tx_fifo,
// checked every cycle against a queue/frame-timing reference model.
module tb_uart_tx_fifo;
  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] q[$];
  bit         m_act;
  bit         m_ovf;
  int         m_start;
  logic [7:0] m_byte;

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .ovf_clr(ovf_clr),
    .full(full),
    .empty(empty),
    .busy(busy),
    .overflow(overflow),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  // line level from position inside the 10-bit frame
  function automatic logic m_tx();
    int b;
    if (!m_act) return 1'b1;
    b = (cyc - m_start) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic step(input logic w,
                      input logic [7:0] d,
                      input logic c,
                      input logic r);
    bit last;
    bit pop;
    bit acc;
    rst     = r;
    wr_en   = w;
    wr_data = d;
    ovf_clr = c;
    @(negedge clk);
    check("tx", {7'd0, tx}, {7'd0, m_tx()});
    check("full", {7'd0, full}, {7'd0, q.size() == D});
    check("empty", {7'd0, empty}, {7'd0, q.size() == 0});
    check("busy", {7'd0, busy},
          {7'd0, m_act || q.size() > 0});
    check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    if (r) begin
      q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
    end else begin
      last = m_act && (cyc == m_start + 10*C - 1);
      pop  = q.size() > 0 && (!m_act || last);
      acc  = w && q.size() < D;
      if (w && !acc)
        m_ovf = 1'b1;
      else if (c)
        m_ovf = 1'b0;
      if (pop) begin
        m_byte  = q.pop_front();
        m_start = cyc + 1;
        m_act   = 1'b1;
      end else if (last) begin
        m_act = 1'b0;
      end
      if (acc) q.push_back(d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    m_act   = 1'b0;
    m_ovf   = 1'b0;
    m_start = 0;
    m_byte  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    idle(3);

    // single byte
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(45);

    // back-to-back
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(85);

    // overflow, then clear race
    for (int i = 1; i <= 6; i++)
      step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(5 * 10 * C + 10);

    // reset during data bit 3 with two bytes queued
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    idle(16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(50);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(45);

    // pointer wrap, never full
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      idle(19 + (i % 3) * 10);
    end
    idle(90);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 24) == 0,
           8'($urandom),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 399) == 0);
    end
    idle(10 * C * (D + 1) + 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
